if_fetch_unit: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. It drives the instruction SRAM and produces the IF-to-ID bus. It consumes the decode stage's branch bus, including capturing a branch redirect that arrives while the PC is stalled. It also holds the fetched instruction steady while ID is stalled, so decode always sees the instruction that matches its PC.

---
 rtl/if_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, redirect capture under stall, SRAM drive and ID-side instruction hold.
// Define IF_ADDR_CHECK_EN to flag misaligned fetch addresses on if_excp_adel and suppress those fetches.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
   parameter int          STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic [32:0]        br_bus,
   output logic [32:0]        if_to_id_bus,
   output logic               inst_sram_en,
   output logic [3:0]         inst_sram_wen,
   output logic [31:0]        inst_sram_addr,
   output logic [31:0]        inst_sram_wdata,
   input  logic [31:0]        inst_sram_rdata,
   output logic [31:0]        id_inst,
   output logic               if_excp_adel
);

   logic        br_e;
   logic [31:0] br_addr;
   logic [31:0] next_pc;
   logic        stall_pc;
   logic        stall_if_id;
   logic        stall_id_ex;

   logic [31:0] pc_q, pc_d;
   logic        ce_q, ce_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic        id_valid_q, id_valid_d;
   logic        adel;

   assign br_e        = br_bus[32];
   assign br_addr     = br_bus[31:0];
   assign stall_pc    = stall[0];
   assign stall_if_id = stall[1];
   assign stall_id_ex = stall[2];

   generate
      if (STALL_W > 3) begin : g_unused_stall
         logic unused_stall_hi;
         assign unused_stall_hi = ^stall[STALL_W-1:3];
      end
   endgenerate

   // A captured redirect outranks a fresh one: it was seen first while the PC was frozen.
   always_comb begin
      if (pend_valid_q) begin
         next_pc = pend_addr_q;
      end else if (br_e) begin
         next_pc = br_addr;
      end else begin
         next_pc = pc_q + 32'd4;
      end
   end

   always_comb begin
      pc_d         = pc_q;
      ce_d         = ce_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      if (!stall_pc) begin
         pc_d         = next_pc;
         ce_d         = 1'b1;
         pend_valid_d = 1'b0;
      end else if (br_e) begin
         pend_addr_d  = br_addr;
         pend_valid_d = 1'b1;
      end
   end

   // id_valid tracks the ce bit ID has registered; a fetch flagged misaligned never counts as valid.
   always_comb begin
      id_valid_d = id_valid_q;
      if (!stall_if_id) begin
         id_valid_d = ce_q & ~adel;
      end else if (!stall_id_ex) begin
         id_valid_d = 1'b0;
      end
   end

   // Grab the SRAM word on the first stalled cycle, before it is overwritten by a re-read of pc_q.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_inst_d  = hold_inst_q;
      if (!stall_if_id || !stall_id_ex) begin
         hold_valid_d = 1'b0;
      end else if (!hold_valid_q) begin
         hold_valid_d = 1'b1;
         hold_inst_d  = inst_sram_rdata;
      end
   end

`ifdef IF_ADDR_CHECK_EN
   logic adel_q, adel_d;

   always_comb begin
      adel_d = adel_q;
      if (!stall_pc) begin
         adel_d = |next_pc[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         adel_q <= 1'b0;
      end else begin
         adel_q <= adel_d;
      end
   end

   assign adel = adel_q;
`else
   assign adel = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q         <= RESET_PC;
         ce_q         <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= 32'b0;
         hold_valid_q <= 1'b0;
         hold_inst_q  <= 32'b0;
         id_valid_q   <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ce_q         <= ce_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         hold_valid_q <= hold_valid_d;
         hold_inst_q  <= hold_inst_d;
         id_valid_q   <= id_valid_d;
      end
   end

   assign inst_sram_en    = ce_q & ~adel;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_addr  = pc_q;
   assign inst_sram_wdata = 32'b0;
   assign if_to_id_bus    = {ce_q, pc_q};
   assign if_excp_adel    = adel;

   always_comb begin
      if (!id_valid_q) begin
         id_inst = 32'b0;
      end else if (hold_valid_q) begin
         id_inst = hold_inst_q;
      end else begin
         id_inst = inst_sram_rdata;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table followed by randomized stalls/redirects against a reference model.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
`ifdef IF_ADDR_CHECK_EN
   localparam bit ADDR_CHK = 1'b1;
`else
   localparam bit ADDR_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic [32:0] if_to_id_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata = 32'b0;
   logic [31:0] id_inst;
   logic        if_excp_adel;

   int checks = 0;
   int errors = 0;

   if_fetch_unit #(.RESET_PC(RESET_PC), .STALL_W(6)) dut (
      .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
      .if_to_id_bus(if_to_id_bus), .inst_sram_en(inst_sram_en),
      .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
      .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
      .id_inst(id_inst), .if_excp_adel(if_excp_adel)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h2401_0001;
   endfunction

   // Synchronous-read SRAM: output keeps its last value when not enabled.
   always @(posedge clk) begin
      if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, got, exp);
      end
   endtask

   task automatic cycle(input bit r, input logic [5:0] s, input bit be, input logic [31:0] ba);
      rst    = r;
      stall  = s;
      br_bus = {be, ba};
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          rst;
      logic [5:0]  stall;
      bit          br_e;
      logic [31:0] br_addr;
      logic [31:0] e_addr;
      bit          e_ce;
      bit          e_en;
      logic [31:0] e_id;
      bit          e_adel;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(bit r, logic [5:0] s, bit be, logic [31:0] ba,
                               logic [31:0] ea, bit ece, bit een, logic [31:0] eid, bit eadel);
      vec_t v;
      v.rst = r; v.stall = s; v.br_e = be; v.br_addr = ba;
      v.e_addr = ea; v.e_ce = ece; v.e_en = een; v.e_id = eid; v.e_adel = eadel;
      return v;
   endfunction

   // Reference model state: PC side plus the pc/valid pair that ID holds.
   logic [31:0] m_pc, m_pend_a, m_idpc;
   bit          m_ce, m_pend_v, m_idv, m_adel;

   task automatic model_step(input bit r, input logic [5:0] s, input bit be, input logic [31:0] ba);
      logic [31:0] npc;
      if (!r) begin
         m_pc = RESET_PC; m_ce = 0; m_pend_v = 0; m_pend_a = 0; m_idv = 0; m_adel = 0;
         return;
      end
      npc = m_pend_v ? m_pend_a : (be ? ba : m_pc + 32'd4);
      if (!s[1]) begin
         m_idv  = m_ce && !m_adel;
         m_idpc = m_pc;
      end else if (!s[2]) begin
         m_idv = 0;
      end
      if (!s[0]) begin
         m_pc = npc; m_ce = 1; m_pend_v = 0;
         m_adel = ADDR_CHK && (npc[1:0] != 2'b00);
      end else if (be) begin
         m_pend_v = 1; m_pend_a = ba;
      end
   endtask

   initial begin
      rst = 1'b0; stall = 6'b0; br_bus = 33'b0;

      tv.push_back(mk(0, 6'h00, 0, 0, RESET_PC, 0, 0, 32'h0, 0));
      tv.push_back(mk(0, 6'h00, 0, 0, RESET_PC, 0, 0, 32'h0, 0));
      tv.push_back(mk(0, 6'h00, 0, 0, RESET_PC, 0, 0, 32'h0, 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0000, 1, 1, 32'h0, 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0004, 1, 1, mem_word(32'hBFC0_0000), 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0008, 1, 1, mem_word(32'hBFC0_0004), 0));
      tv.push_back(mk(1, 6'h00, 1, 32'hBFC0_0100, 32'hBFC0_0100, 1, 1, mem_word(32'hBFC0_0008), 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0104, 1, 1, mem_word(32'hBFC0_0100), 0));
      tv.push_back(mk(1, 6'h03, 1, 32'hBFC0_0200, 32'hBFC0_0104, 1, 1, 32'h0, 0));
      tv.push_back(mk(1, 6'h03, 0, 0, 32'hBFC0_0104, 1, 1, 32'h0, 0));
      tv.push_back(mk(1, 6'h03, 0, 0, 32'hBFC0_0104, 1, 1, 32'h0, 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0200, 1, 1, mem_word(32'hBFC0_0104), 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0204, 1, 1, mem_word(32'hBFC0_0200), 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0208, 1, 1, mem_word(32'hBFC0_0204), 0));
      tv.push_back(mk(1, 6'h07, 0, 0, 32'hBFC0_0208, 1, 1, mem_word(32'hBFC0_0204), 0));
      tv.push_back(mk(1, 6'h07, 0, 0, 32'hBFC0_0208, 1, 1, mem_word(32'hBFC0_0204), 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_020C, 1, 1, mem_word(32'hBFC0_0208), 0));
      tv.push_back(mk(1, 6'h03, 0, 0, 32'hBFC0_020C, 1, 1, 32'h0, 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0210, 1, 1, mem_word(32'hBFC0_020C), 0));
`ifdef IF_ADDR_CHECK_EN
      tv.push_back(mk(1, 6'h00, 1, 32'hBFC0_0102, 32'hBFC0_0102, 1, 0, mem_word(32'hBFC0_0210), 1));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0106, 1, 0, 32'h0, 1));
      tv.push_back(mk(1, 6'h00, 1, 32'hBFC0_0300, 32'hBFC0_0300, 1, 1, 32'h0, 0));
`else
      tv.push_back(mk(1, 6'h00, 1, 32'hBFC0_0102, 32'hBFC0_0102, 1, 1, mem_word(32'hBFC0_0210), 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0106, 1, 1, mem_word(32'hBFC0_0102), 0));
      tv.push_back(mk(1, 6'h00, 1, 32'hBFC0_0300, 32'hBFC0_0300, 1, 1, mem_word(32'hBFC0_0106), 0));
`endif
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0304, 1, 1, mem_word(32'hBFC0_0300), 0));
      tv.push_back(mk(1, 6'h03, 1, 32'hBFC0_0400, 32'hBFC0_0304, 1, 1, 32'h0, 0));
      tv.push_back(mk(0, 6'h03, 0, 0, RESET_PC, 0, 0, 32'h0, 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'hBFC0_0000, 1, 1, 32'h0, 0));
      tv.push_back(mk(1, 6'h00, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, mem_word(32'hBFC0_0000), 0));
      tv.push_back(mk(1, 6'h00, 0, 0, 32'h0000_0000, 1, 1, mem_word(32'hFFFF_FFFC), 0));

      for (int i = 0; i < tv.size(); i++) begin
         cycle(tv[i].rst, tv[i].stall, tv[i].br_e, tv[i].br_addr);
         chk($sformatf("vec%0d_addr", i), {32'b0, inst_sram_addr}, {32'b0, tv[i].e_addr});
         chk($sformatf("vec%0d_bus", i), {31'b0, if_to_id_bus}, {31'b0, tv[i].e_ce, tv[i].e_addr});
         chk($sformatf("vec%0d_en", i), {63'b0, inst_sram_en}, {63'b0, tv[i].e_en});
         chk($sformatf("vec%0d_id_inst", i), {32'b0, id_inst}, {32'b0, tv[i].e_id});
         chk($sformatf("vec%0d_adel", i), {63'b0, if_excp_adel}, {63'b0, tv[i].e_adel});
         chk($sformatf("vec%0d_wen_wdata", i), {28'b0, inst_sram_wen, inst_sram_wdata}, 64'b0);
      end

      // Randomized phase, starting from a reset so model and DUT agree.
      for (int n = 0; n < 2000; n++) begin
         bit          r, be;
         logic [5:0]  s;
         logic [31:0] ba;
         int          k;
         r  = (n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
         k  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
         s  = 6'(((1 << k) - 1));
         be = ($urandom_range(0, 3) == 0);
         ba = {$urandom_range(0, 32'h3FFF), 2'b00} + 32'hBFC0_0000;
         if ($urandom_range(0, 15) == 0) ba[1:0] = 2'($urandom_range(1, 3));
         cycle(r, s, be, ba);
         model_step(r, s, be, ba);
         chk($sformatf("rnd%0d_addr", n), {32'b0, inst_sram_addr}, {32'b0, m_pc});
         chk($sformatf("rnd%0d_bus", n), {31'b0, if_to_id_bus}, {31'b0, m_ce, m_pc});
         chk($sformatf("rnd%0d_en", n), {63'b0, inst_sram_en}, {63'b0, (m_ce && !m_adel)});
         chk($sformatf("rnd%0d_id_inst", n), {32'b0, id_inst},
             {32'b0, (m_idv ? mem_word(m_idpc) : 32'h0)});
         chk($sformatf("rnd%0d_adel", n), {63'b0, if_excp_adel}, {63'b0, m_adel});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
